// File: rtl/rand_seq_checker.sv
// rand_seq_checker: LFSR-driven digit sequence generator with player-entry checker
// and a saturating streak of consecutive correct rounds.
module rand_seq_checker #(
   parameter int          DIGITS     = 4,
   parameter int          DIGIT_W    = 4,
   parameter int          DIGIT_MAX  = 8,
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter int          EARLY_FAIL = 0,
   parameter int          STREAK_W   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          gen,
   input  logic                          abort,
   input  logic                          in_valid,
   input  logic [DIGIT_W-1:0]            in_digit,
   output logic                          in_ready,
   output logic [DIGITS*DIGIT_W-1:0]     seq_out,
   output logic                          seq_valid,
   output logic [$clog2(DIGITS+1)-1:0]   entry_idx,
   output logic                          busy,
   output logic                          done,
   output logic                          correct,
   output logic [STREAK_W-1:0]           streak
);
   localparam int IW = $clog2(DIGITS+1);
   localparam int PW = $clog2(DIGITS);
   typedef enum logic [1:0] {IDLE, GEN, ENTRY, RESULT} state_t;
   state_t                         state_q;
   logic [15:0]                    lfsr_q, lfsr_d;
   logic [DIGITS-1:0][DIGIT_W-1:0] seq_q;
   logic [PW-1:0]                  ptr_q;
   logic [IW-1:0]                  idx_q;
   logic                           match_q;
   logic [STREAK_W-1:0]            streak_q;
   logic [DIGIT_W-1:0]             cand;
   logic                           hit, fin;
   assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   assign cand   = lfsr_q[DIGIT_W-1:0];
   assign hit    = in_digit == seq_q[idx_q[PW-1:0]];
   // Round ends on the last digit, or on the first miss when early-fail is enabled
   assign fin    = (idx_q == IW'(DIGITS-1)) || (EARLY_FAIL != 0 && !hit);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         lfsr_q   <= SEED;
         seq_q    <= '0;
         ptr_q    <= '0;
         idx_q    <= '0;
         match_q  <= 1'b0;
         streak_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         if (abort) begin
            state_q <= IDLE;
            seq_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
         end else begin
            case (state_q)
               IDLE, RESULT: if (gen) begin
                  state_q <= GEN;
                  seq_q   <= '0;
                  ptr_q   <= '0;
                  idx_q   <= '0;
                  match_q <= 1'b1;
               end
               // Rejection sampling: out-of-range nibbles are skipped, never folded
               GEN: if (cand <= DIGIT_W'(DIGIT_MAX)) begin
                  seq_q[ptr_q] <= cand;
                  ptr_q        <= ptr_q + 1'b1;
                  if (ptr_q == PW'(DIGITS-1)) state_q <= ENTRY;
               end
               ENTRY: if (in_valid) begin
                  match_q <= match_q & hit;
                  idx_q   <= idx_q + 1'b1;
                  if (fin) begin
                     state_q  <= RESULT;
                     streak_q <= (match_q & hit) ? (&streak_q ? streak_q : streak_q + 1'b1) : '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end
   assign in_ready  = state_q == ENTRY;
   assign seq_valid = state_q == ENTRY || state_q == RESULT;
   assign busy      = state_q == GEN;
   assign done      = state_q == RESULT;
   assign correct   = done & match_q;
   assign seq_out   = seq_q;
   assign entry_idx = idx_q;
   assign streak    = streak_q;
endmodule

// File: doc/rand_seq_checker.md
Name: rand_seq_checker

Overview:
Parametrised digit-sequence generator and checker for the memorization game. A free-running LFSR supplies pseudo-random digits. On request, the block builds a DIGITS-long sequence of values in 0..DIGIT_MAX and presents it for display. It then accepts the player's digits one at a time and reports pass or fail. It also keeps a streak of consecutive passed rounds.

Parameters:
DIGITS, 4, number of digits per sequence (2..8)
DIGIT_W, 4, bits per digit
DIGIT_MAX, 8, largest legal digit value; must be < 2**DIGIT_W
SEED, 16'hACE1, LFSR reset value; must be nonzero
EARLY_FAIL, 0, 1 = end the round at the first wrong digit; 0 = always collect all DIGITS entries
STREAK_W, 8, width of the streak counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
gen  input  1  start a new round; sampled in IDLE and RESULT only
abort  input  1  abandon the current round and return to IDLE
in_valid  input  1  player digit strobe
in_digit  input  DIGIT_W  player digit
in_ready  output  1  high only in ENTRY
seq_out  output  DIGITS*DIGIT_W  generated sequence; digit k is at [k*DIGIT_W +: DIGIT_W]
seq_valid  output  1  seq_out holds a complete sequence (ENTRY and RESULT)
entry_idx  output  $clog2(DIGITS+1)  count of digits accepted this round
busy  output  1  high in GEN
done  output  1  high in RESULT
correct  output  1  round result; meaningful only while done=1
streak  output  STREAK_W  consecutive correct rounds, saturating

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, lfsr=SEED, seq_out=0, entry_idx=0, streak=0. All 1-bit outputs are 0.
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400.
  - Each edge: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances on every clock edge in every state.
- States: IDLE, GEN, ENTRY, RESULT. Encoding is free.
- IDLE: gen=1 -> GEN. Clear seq_out, entry_idx and the internal digit pointer.
- GEN (busy=1): each edge inspects the current (pre-step) lfsr[DIGIT_W-1:0].
  - If the value is <= DIGIT_MAX, store it as the next digit, starting at k=0.
  - Otherwise reject it and store nothing (rejection sampling; no modulo).
  - The edge that stores digit DIGITS-1 moves the block to ENTRY.
  - Latency is variable: at least DIGITS edges.
  - gen is ignored while in GEN.
- ENTRY (in_ready=1, seq_valid=1): on each edge with in_valid=1:
  - Compare in_digit with digit[entry_idx]; AND the outcome into an internal match flag that is set to 1 when the round starts.
  - Increment entry_idx.
  - When entry_idx reaches DIGITS, go to RESULT.
  - With EARLY_FAIL=1, the first mismatch goes to RESULT immediately; entry_idx still increments for that digit.
- RESULT (done=1, seq_valid=1): correct = match flag.
  - The streak updates once, on the edge that enters RESULT.
  - Correct round: streak +1, saturating at all-ones.
  - Wrong round: streak = 0.
  - gen=1 -> GEN (new round; same clearing as from IDLE).
- abort=1 from any state -> IDLE on the next edge.
  - Clears seq_valid, seq_out and entry_idx.
  - streak is unchanged.
  - abort has priority over gen and in_valid in the same cycle.
- in_valid outside ENTRY is ignored; no counters move.
- Reset asserted mid-round: immediate return to the reset state, including streak=0 and lfsr=SEED.
- All outputs are registered or decoded from state; there are no combinational input-to-output paths.

Test Plan:
- Reset values: hold rst=0, then release -> state IDLE, seq_valid=0, busy=0, done=0, streak=0, seq_out=0.
- Known sequence: default parameters, gen=1 at the first edge after rst release.
  - Required: busy for edges 2..7; LFSR values E270, 7138, 389C, 1C4E, 0E27, B313.
  - Nibbles C and E are rejected.
  - seq_out=16'h3780 with seq_valid=1 after edge 7.
- Correct entry: enter digits 0, 8, 7, 3 with in_valid gaps of 0 and 2 cycles -> entry_idx 1..4, done=1, correct=1, streak=1. A second correct round -> streak=2.
- Wrong entry: EARLY_FAIL=0 and entries 0, 8, 5, 3 -> done only after the 4th digit, correct=0, streak=0. With EARLY_FAIL=1 -> done after the 3rd digit, entry_idx=3.
- Abort and priority:
  - abort during GEN -> IDLE, seq_valid=0.
  - abort together with in_valid in ENTRY -> digit is not counted, state IDLE.
  - gen during ENTRY -> ignored.
- Saturation: STREAK_W=2 and 4 correct rounds -> streak stays 3; then a wrong round -> 0.
